// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: steers user_input through account, password, menu,
// currency and destination fields, drives authentication/ledger requests and
// enforces the retry lockout and the inactivity timeout.
module atm_session_ctrl #(
  parameter int MAX_TRIES      = 3,
  parameter int LOCK_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        entry_valid,
  input  logic [3:0]  status_code_in,
  input  logic [1:0]  usr_input_in,
  input  logic        auth_ok,
  input  logic        auth_fail,
  input  logic        txn_done,
  input  logic        txn_err,
  output logic [15:0] current_state,
  output logic [3:0]  input_style_out,
  output logic        auth_req,
  output logic        txn_req,
  output logic [1:0]  txn_type,
  output logic        session_active,
  output logic        locked,
  output logic [3:0]  err_code
);

  typedef enum logic [15:0] {
    ST_ACCT = 16'h0001,
    ST_PSWD = 16'h0002,
    ST_AUTH = 16'h0004,
    ST_MENU = 16'h0008,
    ST_CURR = 16'h0010,
    ST_DEST = 16'h0020,
    ST_EXEC = 16'h0040,
    ST_LOCK = 16'h0080
  } state_e;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_ONE  = LW'(1);
  localparam logic [2:0]    MAX_T     = 3'(MAX_TRIES);

  // Field format selector presented to user_input for each state.
  function automatic logic [3:0] style_of(input state_e s);
    case (s)
      ST_ACCT: style_of = 4'b0010;
      ST_PSWD: style_of = 4'b0011;
      ST_MENU: style_of = 4'b0100;
      ST_CURR: style_of = 4'b0101;
      ST_DEST: style_of = 4'b0110;
      default: style_of = 4'b0000;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      style_q;
  logic            auth_req_q, txn_req_q, active_q, locked_q;
  logic [1:0]      txn_type_q, txn_type_d;
  logic [3:0]      err_q, err_d;
  logic [2:0]      att_q, att_d, att_inc;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [LW-1:0]   lock_q, lock_d;
  logic            is_entry, accept, reject, tmo_hit;

  // Next-state, error, attempt, timeout and lock-counter computation.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    att_d      = att_q;
    txn_type_d = txn_type_q;
    lock_d     = {LW{1'b0}};
    att_inc    = (att_q == 3'd7) ? 3'd7 : (att_q + 3'd1);
    is_entry   = (state_q == ST_ACCT) || (state_q == ST_PSWD) || (state_q == ST_MENU) ||
                 (state_q == ST_CURR) || (state_q == ST_DEST);
    accept     = is_entry && entry_valid && (status_code_in == 4'h0);
    reject     = is_entry && entry_valid && (status_code_in != 4'h0);
    tmo_hit    = is_entry && !entry_valid && (tmo_q == TMO_LAST);

    if (accept) begin
      err_d = 4'h0;
    end else if (reject) begin
      err_d = status_code_in;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      ST_ACCT: state_d = accept ? ST_PSWD : ST_ACCT;
      ST_PSWD: state_d = accept ? ST_AUTH : ST_PSWD;
      ST_AUTH: begin
        // A simultaneous ok/fail is resolved as a failure.
        if (auth_fail) begin
          att_d   = att_inc;
          err_d   = 4'hA;
          state_d = (att_inc == MAX_T) ? ST_LOCK : ST_ACCT;
        end else if (auth_ok) begin
          att_d   = 3'd0;
          state_d = ST_MENU;
        end else begin
          state_d = ST_AUTH;
        end
      end
      ST_MENU: begin
        if (accept) begin
          case (usr_input_in)
            2'b00: begin txn_type_d = 2'b00; state_d = ST_EXEC; end
            2'b01: begin txn_type_d = 2'b01; state_d = ST_CURR; end
            2'b10: begin txn_type_d = 2'b10; state_d = ST_CURR; end
            default: state_d = ST_ACCT;
          endcase
        end else begin
          state_d = ST_MENU;
        end
      end
      ST_CURR: begin
        if (accept) begin
          state_d = (txn_type_q == 2'b10) ? ST_DEST : ST_EXEC;
        end else begin
          state_d = ST_CURR;
        end
      end
      ST_DEST: state_d = accept ? ST_EXEC : ST_DEST;
      ST_EXEC: begin
        if (txn_done) begin
          state_d = ST_MENU;
          err_d   = txn_err ? 4'hE : err_q;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_LOCK: begin
        if (lock_q == LOCK_LAST) begin
          state_d = ST_ACCT;
          att_d   = 3'd0;
        end else begin
          lock_d  = lock_q + LOCK_ONE;
        end
      end
      default: state_d = ST_ACCT;
    endcase

    // Idle timeout aborts the session; a same-cycle entry suppresses it.
    if (tmo_hit) begin
      state_d = ST_ACCT;
      err_d   = 4'hF;
    end else begin
      state_d = state_d;
    end

    if (!is_entry || entry_valid || tmo_hit || (state_d != state_q)) begin
      tmo_d = {TW{1'b0}};
    end else begin
      tmo_d = tmo_q + TMO_ONE;
    end
  end

  // State, counters and all outputs, registered from the next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACCT;
      style_q    <= 4'b0010;
      auth_req_q <= 1'b0;
      txn_req_q  <= 1'b0;
      active_q   <= 1'b0;
      locked_q   <= 1'b0;
      txn_type_q <= 2'b00;
      err_q      <= 4'h0;
      att_q      <= 3'd0;
      tmo_q      <= {TW{1'b0}};
      lock_q     <= {LW{1'b0}};
    end else begin
      state_q    <= state_d;
      style_q    <= style_of(state_d);
      auth_req_q <= (state_d == ST_AUTH);
      txn_req_q  <= (state_d == ST_EXEC);
      active_q   <= (state_d == ST_MENU) || (state_d == ST_CURR) ||
                    (state_d == ST_DEST) || (state_d == ST_EXEC);
      locked_q   <= (state_d == ST_LOCK);
      txn_type_q <= txn_type_d;
      err_q      <= err_d;
      att_q      <= att_d;
      tmo_q      <= tmo_d;
      lock_q     <= lock_d;
    end
  end

  assign current_state   = state_q;
  assign input_style_out = style_q;
  assign auth_req        = auth_req_q;
  assign txn_req         = txn_req_q;
  assign txn_type        = txn_type_q;
  assign session_active  = active_q;
  assign locked          = locked_q;
  assign err_code        = err_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl with short lock and timeout windows.
module tb_atm_session_ctrl;

  localparam int LOCKC = 20;
  localparam int TMO   = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        entry_valid = 1'b0;
  logic [3:0]  status_code_in = 4'h0;
  logic [1:0]  usr_input_in = 2'b00;
  logic        auth_ok = 1'b0;
  logic        auth_fail = 1'b0;
  logic        txn_done = 1'b0;
  logic        txn_err = 1'b0;
  logic [15:0] current_state;
  logic [3:0]  input_style_out;
  logic        auth_req, txn_req, session_active, locked;
  logic [1:0]  txn_type;
  logic [3:0]  err_code;

  int n_checks = 0;
  int n_pass   = 0;

  atm_session_ctrl #(.MAX_TRIES(3), .LOCK_CYCLES(LOCKC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .entry_valid(entry_valid), .status_code_in(status_code_in),
    .usr_input_in(usr_input_in), .auth_ok(auth_ok), .auth_fail(auth_fail),
    .txn_done(txn_done), .txn_err(txn_err), .current_state(current_state),
    .input_style_out(input_style_out), .auth_req(auth_req), .txn_req(txn_req),
    .txn_type(txn_type), .session_active(session_active), .locked(locked),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_entry(input logic [3:0] st, input logic [1:0] ch);
    entry_valid = 1'b1; status_code_in = st; usr_input_in = ch;
    step();
    entry_valid = 1'b0; status_code_in = 4'h0; usr_input_in = 2'b00;
  endtask

  task automatic pulse_auth(input logic ok, input logic fail);
    auth_ok = ok; auth_fail = fail;
    step();
    auth_ok = 1'b0; auth_fail = 1'b0;
  endtask

  task automatic pulse_txn(input logic err);
    txn_done = 1'b1; txn_err = err;
    step();
    txn_done = 1'b0; txn_err = 1'b0;
  endtask

  task automatic login();
    do_entry(4'h0, 2'b00);
    do_entry(4'h0, 2'b00);
    pulse_auth(1'b1, 1'b0);
  endtask

  task automatic fail_once(input logic both);
    do_entry(4'h0, 2'b00);
    do_entry(4'h0, 2'b00);
    pulse_auth(both, 1'b1);
  endtask

  initial begin
    // Reset values
    #12;
    check_eq("rst_state", current_state, 16'h0001);
    check_eq("rst_style", {12'h000, input_style_out}, 16'h0002);
    check_eq("rst_err", {12'h000, err_code}, 16'h0000);
    check_eq("rst_outs", {11'h000, auth_req, txn_req, session_active, locked, 1'b0}, 16'h0000);
    rst_n = 1'b1;
    step();

    // Rejected then accepted entry in ACCT
    do_entry(4'h3, 2'b00);
    check_eq("rej_state", current_state, 16'h0001);
    check_eq("rej_err", {12'h000, err_code}, 16'h0003);
    do_entry(4'h0, 2'b00);
    check_eq("pswd_state", current_state, 16'h0002);
    check_eq("pswd_err", {12'h000, err_code}, 16'h0000);
    check_eq("pswd_style", {12'h000, input_style_out}, 16'h0003);
    do_entry(4'h0, 2'b00);
    check_eq("auth_state", current_state, 16'h0004);
    check_eq("auth_req", {15'h0000, auth_req}, 16'h0001);
    check_eq("auth_style", {12'h000, input_style_out}, 16'h0000);
    pulse_txn(1'b0);
    check_eq("auth_ign_txn", current_state, 16'h0004);

    // Transfer path with failing transaction
    pulse_auth(1'b1, 1'b0);
    check_eq("menu_state", current_state, 16'h0008);
    check_eq("menu_active", {15'h0000, session_active}, 16'h0001);
    check_eq("menu_authreq", {15'h0000, auth_req}, 16'h0000);
    check_eq("menu_style", {12'h000, input_style_out}, 16'h0004);
    do_entry(4'h0, 2'b10);
    check_eq("curr_state", current_state, 16'h0010);
    check_eq("curr_style", {12'h000, input_style_out}, 16'h0005);
    do_entry(4'h0, 2'b00);
    check_eq("dest_state", current_state, 16'h0020);
    check_eq("dest_style", {12'h000, input_style_out}, 16'h0006);
    do_entry(4'h0, 2'b00);
    check_eq("exec_state", current_state, 16'h0040);
    check_eq("exec_txnreq", {15'h0000, txn_req}, 16'h0001);
    check_eq("exec_type", {14'h0000, txn_type}, 16'h0002);
    pulse_txn(1'b1);
    check_eq("txnerr_state", current_state, 16'h0008);
    check_eq("txnerr_err", {12'h000, err_code}, 16'h000E);
    check_eq("txnerr_req", {15'h0000, txn_req}, 16'h0000);

    // Withdraw path skips DEST, then logout
    do_entry(4'h0, 2'b01);
    check_eq("wd_curr", current_state, 16'h0010);
    check_eq("wd_err", {12'h000, err_code}, 16'h0000);
    do_entry(4'h0, 2'b00);
    check_eq("wd_exec", current_state, 16'h0040);
    check_eq("wd_type", {14'h0000, txn_type}, 16'h0001);
    pulse_txn(1'b0);
    check_eq("wd_menu", current_state, 16'h0008);
    do_entry(4'h0, 2'b11);
    check_eq("logout_state", current_state, 16'h0001);
    check_eq("logout_active", {15'h0000, session_active}, 16'h0000);

    // Two fails, a success clears attempts, then three fails lock
    fail_once(1'b0);
    check_eq("fail1_state", current_state, 16'h0001);
    check_eq("fail1_err", {12'h000, err_code}, 16'h000A);
    fail_once(1'b0);
    login();
    do_entry(4'h0, 2'b11);
    fail_once(1'b0);
    fail_once(1'b0);
    check_eq("fail2_nolock", current_state, 16'h0001);
    fail_once(1'b1);
    check_eq("lock_state", current_state, 16'h0080);
    check_eq("lock_flag", {15'h0000, locked}, 16'h0001);
    check_eq("lock_err", {12'h000, err_code}, 16'h000A);
    do_entry(4'h0, 2'b00);
    check_eq("lock_ign_state", current_state, 16'h0080);
    check_eq("lock_ign_err", {12'h000, err_code}, 16'h000A);
    repeat (LOCKC - 2) step();
    check_eq("lock_hold", current_state, 16'h0080);
    step();
    check_eq("unlock_state", current_state, 16'h0001);
    check_eq("unlock_flag", {15'h0000, locked}, 16'h0000);
    fail_once(1'b0);
    fail_once(1'b0);
    check_eq("relock_pre", current_state, 16'h0001);
    fail_once(1'b0);
    check_eq("relock_state", current_state, 16'h0080);

    // Async reset out of LOCK
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_lock_state", current_state, 16'h0001);
    check_eq("arst_lock_flag", {15'h0000, locked}, 16'h0000);
    rst_n = 1'b1;
    step();

    // Inactivity timeout in MENU
    login();
    check_eq("tmo_menu", current_state, 16'h0008);
    repeat (TMO - 1) step();
    check_eq("tmo_before", current_state, 16'h0008);
    step();
    check_eq("tmo_state", current_state, 16'h0001);
    check_eq("tmo_err", {12'h000, err_code}, 16'h000F);

    // Entry on the timeout cycle wins
    login();
    repeat (TMO - 1) step();
    do_entry(4'h0, 2'b00);
    check_eq("tmo_race_state", current_state, 16'h0040);
    check_eq("tmo_race_err", {12'h000, err_code}, 16'h0000);
    check_eq("tmo_race_type", {14'h0000, txn_type}, 16'h0000);
    repeat (TMO + 10) step();
    check_eq("exec_no_tmo", current_state, 16'h0040);
    check_eq("exec_req_hold", {15'h0000, txn_req}, 16'h0001);

    // Async reset from EXEC takes effect without a clock edge
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_txnreq", {15'h0000, txn_req}, 16'h0000);
    check_eq("arst_state", current_state, 16'h0001);
    check_eq("arst_active", {15'h0000, session_active}, 16'h0000);
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
